// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch front end with credit-limited requests and an output FIFO.
// Define RISCV_FETCH_MISALIGN_EN to report misaligned redirect targets through out_fault.
module riscv_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESETVEC = XLEN'(32'h8000_0000),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
`ifdef RISCV_FETCH_MISALIGN_EN
    ,
    output logic            out_fault
`endif
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "riscv_fetch: XLEN must be 32 or 64");
        end
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "riscv_fetch: DEPTH must be a power of two in 2..16");
        end
    endgenerate

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [XLEN-1:0] r_pc_mem  [DEPTH];
    logic [31:0]     r_ins_mem [DEPTH];

    logic [CW:0]     w_inuse;
    logic            w_halted;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_keep;
    logic            w_flt_push;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_push_pc;
    logic [31:0]     w_push_ins;

`ifdef RISCV_FETCH_MISALIGN_EN
    logic             r_halted;
    logic             r_fault_pend;
    logic [XLEN-1:0]  r_fault_pc;
    logic [DEPTH-1:0] r_flt_mem;
    logic             w_misal;

    assign w_misal    = redirect_pc[1:0] != 2'b00;
    assign w_redir_pc = redirect_pc;
    assign w_halted   = r_halted;
    // Fault entry waits until every stale response has been drained.
    assign w_flt_push = r_fault_pend && (r_drop == '0) && !redirect_valid;
    assign w_push_pc  = w_flt_push ? r_fault_pc : r_rsp_pc;
    assign w_push_ins = w_flt_push ? 32'h0 : imem_rsp_data;
    assign out_fault  = r_flt_mem[r_rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halted     <= 1'b0;
            r_fault_pend <= 1'b0;
            r_fault_pc   <= RESETVEC;
            r_flt_mem    <= '0;
        end else if (redirect_valid) begin
            r_halted     <= w_misal;
            r_fault_pend <= w_misal;
            r_fault_pc   <= redirect_pc;
        end else begin
            if (w_flt_push) begin
                r_fault_pend <= 1'b0;
            end
            if (w_push) begin
                r_flt_mem[r_wptr] <= w_flt_push;
            end
        end
    end
`else
    logic w_unused;

    assign w_unused   = ^redirect_pc[1:0];
    assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_halted   = 1'b0;
    assign w_flt_push = 1'b0;
    assign w_push_pc  = r_rsp_pc;
    assign w_push_ins = imem_rsp_data;
`endif

    // Credit covers both in-flight requests and buffered entries.
    assign w_inuse     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid = !reset && !redirect_valid && !w_halted && (w_inuse < LIMIT);
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_keep      = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_push      = w_keep || w_flt_push;
    assign out_valid   = (r_count != '0) && !redirect_valid;
    assign w_pop       = out_valid && out_ready;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_pc         = r_pc_mem[r_rptr];
    assign out_instr      = r_ins_mem[r_rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESETVEC;
            r_rsp_pc      <= RESETVEC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc_mem[i]  <= RESETVEC;
                r_ins_mem[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            // Everything still owed by memory becomes stale.
            r_fetch_pc    <= w_redir_pc;
            r_rsp_pc      <= w_redir_pc;
            r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
            r_drop        <= r_outstanding - CW'(imem_rsp_valid);
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_keep) begin
                r_rsp_pc <= r_rsp_pc + XLEN'(4);
            end
            if (w_push) begin
                r_pc_mem[r_wptr]  <= w_push_pc;
                r_ins_mem[r_wptr] <= w_push_ins;
                r_wptr            <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed and randomised stimulus for riscv_fetch with a
// transaction-level scoreboard (epoch-tagged requests, expected output queue).
module tb_riscv_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
`ifdef RISCV_FETCH_MISALIGN_EN
    logic        out_fault;
    logic        out_fault32;
`endif

    logic        req_valid32;
    logic        req_ready32;
    logic [31:0] req_addr32;
    logic        rsp_valid32;
    logic [31:0] rsp_data32;
    logic        redir32;
    logic [31:0] redir_pc32;
    logic        out_valid32;
    logic        out_ready32;
    logic [31:0] out_pc32;
    logic [31:0] out_instr32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_fetch #(.XLEN(64), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
`ifdef RISCV_FETCH_MISALIGN_EN
        .out_fault      (out_fault),
`endif
        .out_instr      (out_instr)
    );

    riscv_fetch #(.XLEN(32), .DEPTH(4)) u_dut32 (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid32),
        .imem_req_ready (req_ready32),
        .imem_req_addr  (req_addr32),
        .imem_rsp_valid (rsp_valid32),
        .imem_rsp_data  (rsp_data32),
        .redirect_valid (redir32),
        .redirect_pc    (redir_pc32),
        .out_valid      (out_valid32),
        .out_ready      (out_ready32),
        .out_pc         (out_pc32),
`ifdef RISCV_FETCH_MISALIGN_EN
        .out_fault      (out_fault32),
`endif
        .out_instr      (out_instr32)
    );

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory environment: in-order responses, latency mem_lat, no backpressure.
    logic [63:0] mq_addr[$];
    int          mq_due[$];
    int          mem_lat = 1;
    logic        mem_ready = 1'b1;
    int          cyc = 0;

    // Scoreboard state.
    logic [63:0] inf_addr[$];
    int          inf_ep[$];
    logic [63:0] eq_pc[$];
    logic [31:0] eq_ins[$];
    logic        eq_flt[$];
    int          epoch = 0;
    logic [63:0] exp_req = 64'h8000_0000;
    logic        m_halt = 1'b0;
    logic        m_fpend = 1'b0;
    logic [63:0] m_fpc = 64'h0;

    assign imem_req_ready = mem_ready;

    always @(posedge clk) begin
        if (reset) begin
            inf_addr.delete(); inf_ep.delete();
            eq_pc.delete(); eq_ins.delete(); eq_flt.delete();
            epoch = 0; exp_req = 64'h8000_0000;
            m_halt = 1'b0; m_fpend = 1'b0;
            mq_addr.delete(); mq_due.delete();
        end else begin
            if (out_valid && out_ready && eq_pc.size() > 0) begin
                void'(eq_pc.pop_front()); void'(eq_ins.pop_front()); void'(eq_flt.pop_front());
            end
            if (redirect_valid) begin
                if (imem_rsp_valid && inf_addr.size() > 0) begin
                    void'(inf_addr.pop_front()); void'(inf_ep.pop_front());
                end
                eq_pc.delete(); eq_ins.delete(); eq_flt.delete();
                epoch++;
`ifdef RISCV_FETCH_MISALIGN_EN
                m_halt = redirect_pc[1:0] != 2'b00;
                m_fpend = m_halt;
                m_fpc = redirect_pc;
                exp_req = redirect_pc;
`else
                exp_req = {redirect_pc[63:2], 2'b00};
`endif
            end else begin
                if (m_fpend && inf_addr.size() == 0) begin
                    eq_pc.push_back(m_fpc); eq_ins.push_back(32'h0); eq_flt.push_back(1'b1);
                    m_fpend = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    inf_addr.push_back(exp_req); inf_ep.push_back(epoch);
                    exp_req = exp_req + 64'd4;
                end
                if (imem_rsp_valid && inf_addr.size() > 0) begin
                    if (inf_ep[0] == epoch) begin
                        eq_pc.push_back(inf_addr[0]);
                        eq_ins.push_back(memf(inf_addr[0]));
                        eq_flt.push_back(1'b0);
                    end
                    void'(inf_addr.pop_front()); void'(inf_ep.pop_front());
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr); mq_due.push_back(cyc + mem_lat);
            end
            if (imem_rsp_valid && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front()); void'(mq_due.pop_front());
            end
        end
        cyc++;
        #1;
        if (!reset && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Compare process: every cycle, outputs against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("req_valid", 64'(imem_req_valid),
                64'(!redirect_valid && !m_halt && (inf_addr.size() + eq_pc.size() < DEPTH)));
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
            chk("out_valid", 64'(out_valid), 64'(eq_pc.size() > 0 && !redirect_valid));
            if (out_valid && eq_pc.size() > 0) begin
                chk("out_pc", out_pc, eq_pc[0]);
                chk("out_instr", 64'(out_instr), 64'(eq_ins[0]));
`ifdef RISCV_FETCH_MISALIGN_EN
                chk("out_fault", 64'(out_fault), 64'(eq_flt[0]));
`endif
            end
        end
    end

    // XLEN=32 instance: latency-1 responder.
    always @(posedge clk) begin
        logic p;
        logic [31:0] a;
        p = req_valid32 && req_ready32 && !reset;
        a = req_addr32;
        #1;
        rsp_valid32 = p;
        rsp_data32  = a ^ 32'h1357_9BDF;
    end

    task automatic wait_out(input string tag, input int bound);
        @(negedge clk);
        for (int i = 0; i < bound && !out_valid; i++) @(negedge clk);
        if (!out_valid) begin
            n_checks++; n_errors++;
            $display("FAIL %s: out_valid low for %0d cycles, required high", tag, bound);
        end
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int found;
        logic [63:0] got[$];
        redirect_valid = 0; redirect_pc = 0; out_ready = 1;
        imem_rsp_valid = 0; imem_rsp_data = 0;
        req_ready32 = 1; out_ready32 = 1; redir32 = 0; redir_pc32 = 0;
        rsp_valid32 = 0; rsp_data32 = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("rst_out_pc", out_pc, 64'h8000_0000);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
`ifdef RISCV_FETCH_MISALIGN_EN
        chk("rst_out_fault", 64'(out_fault), 64'h0);
`endif
        @(posedge clk); #1 reset = 0;

        // Latency 1, full throughput from reset vector.
        @(negedge clk);
        chk("t1_first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_first_req_addr", imem_req_addr, 64'h8000_0000);
        wait_out("t1_wait", 10);
        chk("t1_out_pc0", out_pc, 64'h8000_0000);
        chk("t1_out_instr0", 64'(out_instr), 64'h9357_9BDF);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("t1_stream_valid", 64'(out_valid), 64'd1);
            chk("t1_stream_pc", out_pc, 64'h8000_0000 + 64'(4 * k));
        end

        // Reset mid-operation, then latency 3 with decode stalled.
        @(posedge clk); #1;
        reset = 1; mem_lat = 3; out_ready = 0;
        @(posedge clk); #1 reset = 0;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc++;
        end
        chk("t2_accepted_stalled", 64'(acc), 64'd4);
        chk("t2_req_blocked", 64'(imem_req_valid), 64'd0);
        @(posedge clk); #1 out_ready = 1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc++;
        end
        chk("t2_resumed", 64'(acc > 0), 64'd1);

        // Redirect with three requests in flight.
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(posedge clk); #1;
            if (inf_addr.size() == 3) found = 1;
        end
        chk("t3_three_inflight", 64'(found), 64'd1);
        redirect_valid = 1; redirect_pc = 64'h8000_0100;
        @(posedge clk); #1 redirect_valid = 0;
        wait_out("t3_wait", 20);
        chk("t3_out_pc", out_pc, 64'h8000_0100);
        chk("t3_out_instr", 64'(out_instr), 64'h9357_9ADF);

        // Redirect coinciding with a response, then another one cycle later.
        mem_lat = 2;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(posedge clk); #2;
            if (imem_rsp_valid) found = 1;
        end
        chk("t4_rsp_seen", 64'(found), 64'd1);
        redirect_valid = 1; redirect_pc = 64'h8000_0300;
        @(posedge clk); #1 redirect_valid = 0;
        @(posedge clk); #1 redirect_valid = 1; redirect_pc = 64'h8000_0400;
        @(posedge clk); #1 redirect_valid = 0;
        wait_out("t4_wait", 20);
        chk("t4_out_pc", out_pc, 64'h8000_0400);
        chk("t4_out_instr", 64'(out_instr), 64'h9357_9FDF);

        // 64-bit address wrap.
        mem_lat = 1;
        redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
        got.delete();
        for (int k = 0; k < 20 && got.size() < 3; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) got.push_back(imem_req_addr);
        end
        chk("t5_nreq", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("t5_addr0", got[0], 64'hFFFF_FFFF_FFFF_FFF8);
            chk("t5_addr1", got[1], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("t5_addr2", got[2], 64'h0);
        end

        // Random backpressure, latency and redirects.
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            out_ready = $urandom_range(0, 3) != 0;
            mem_ready = $urandom_range(0, 3) != 0;
            mem_lat = int'($urandom_range(1, 3));
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
        end
        @(posedge clk); #1;
        out_ready = 1; mem_ready = 1; mem_lat = 1; redirect_valid = 0;

        // Misaligned redirect target.
        redirect_to(64'h8000_0102);
        wait_out("t7_wait", 20);
`ifdef RISCV_FETCH_MISALIGN_EN
        chk("t7_fault_pc", out_pc, 64'h8000_0102);
        chk("t7_fault_flag", 64'(out_fault), 64'd1);
        chk("t7_fault_instr", 64'(out_instr), 64'h0);
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_req_valid) acc++;
        end
        chk("t7_halted_no_req", 64'(acc), 64'd0);
        redirect_to(64'h8000_0200);
        wait_out("t7_resume_wait", 20);
        chk("t7_resume_pc", out_pc, 64'h8000_0200);
        chk("t7_resume_flag", 64'(out_fault), 64'd0);
`else
        chk("t7_forced_pc", out_pc, 64'h8000_0100);
        chk("t7_forced_instr", 64'(out_instr), 64'h9357_9ADF);
`endif

        // XLEN=32 wrap.
        @(posedge clk); #1 redir32 = 1; redir_pc32 = 32'hFFFF_FFFC;
        @(posedge clk); #1 redir32 = 0;
        got.delete();
        for (int k = 0; k < 10 && got.size() < 2; k++) begin
            @(negedge clk);
            if (req_valid32 && req_ready32) got.push_back(64'(req_addr32));
        end
        chk("t8_nreq", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("t8_addr0", got[0], 64'hFFFF_FFFC);
            chk("t8_addr1", got[1], 64'h0);
        end
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            if (out_valid32) found = 1;
            else @(negedge clk);
        end
        chk("t8_out_seen", 64'(found), 64'd1);
        chk("t8_out_pc", 64'(out_pc32), 64'hFFFF_FFFC);
        chk("t8_out_instr", 64'(out_instr32), 64'hECA8_6423);
        @(negedge clk);
        chk("t8_out_pc_wrap", 64'(out_pc32), 64'h0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
